// File: rtl/seq_tx_if.sv
// seq_tx_if: request/stream bundle between a pattern source and seq_tx.
// master drives the transmit request, slave (seq_tx) drives the serial stream.
interface seq_tx_if #(
    parameter int PAT_W = 4
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [3:0]       reps;
    logic             abort;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, reps, abort,
        input  serial_out, busy, done
    );

    modport slave (
        input  start, pattern, reps, abort,
        output serial_out, busy, done
    );
endinterface

// File: rtl/seq_tx.sv
// seq_tx: serializes a PAT_W-bit pattern MSB first, repeated reps times
// (0 means once), then pulses done for one cycle. All outputs are registered.
// Optional macro SEQ_TX_GAP_EN inserts one idle-level GAP cycle between
// consecutive repetitions (never after the last one).
module seq_tx #(
    parameter int PAT_W = 4
) (
    input  logic    clk,
    input  logic    n_rst,
    seq_tx_if.slave bus
);
    localparam int             CW   = $clog2(PAT_W);
    localparam logic [CW-1:0]  LAST = CW'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;      // captured pattern, reloaded per repetition
    logic [PAT_W-1:0] shreg_q;    // bits still to be sent, MSB next
    logic [CW-1:0]    bitcnt_q;   // index of the bit currently on serial_out
    logic [3:0]       repcnt_q;   // repetitions left including the current one
    logic             sout_q;
    logic             busy_q;
    logic             done_q;

    assign bus.serial_out = sout_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    // Transmit FSM: state, datapath and registered outputs in one block.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            repcnt_q <= '0;
            sout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    // start wins over a coincident abort here
                    if (bus.start) begin
                        pat_q    <= bus.pattern;
                        shreg_q  <= {bus.pattern[PAT_W-2:0], 1'b0};
                        bitcnt_q <= '0;
                        repcnt_q <= (bus.reps == 4'd0) ? 4'd1 : bus.reps;
                        sout_q   <= bus.pattern[PAT_W-1];
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state_q  <= IDLE;
                        sout_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        bitcnt_q <= '0;
                        repcnt_q <= '0;
                        shreg_q  <= '0;
                    end else if (bitcnt_q == LAST) begin
                        if (repcnt_q == 4'd1) begin
                            state_q <= DONE;
                            sout_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            repcnt_q <= repcnt_q - 4'd1;
`ifdef SEQ_TX_GAP_EN
                            state_q  <= GAP;
                            sout_q   <= 1'b0;
`else
                            // next repetition's MSB follows with no idle bit
                            bitcnt_q <= '0;
                            sout_q   <= pat_q[PAT_W-1];
                            shreg_q  <= {pat_q[PAT_W-2:0], 1'b0};
`endif
                        end
                    end else begin
                        sout_q   <= shreg_q[PAT_W-1];
                        shreg_q  <= {shreg_q[PAT_W-2:0], 1'b0};
                        bitcnt_q <= bitcnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state_q  <= IDLE;
                        sout_q   <= 1'b0;
                        busy_q   <= 1'b0;
                        bitcnt_q <= '0;
                        repcnt_q <= '0;
                        shreg_q  <= '0;
                    end else begin
                        state_q  <= SHIFT;
                        bitcnt_q <= '0;
                        sout_q   <= pat_q[PAT_W-1];
                        shreg_q  <= {pat_q[PAT_W-2:0], 1'b0};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    sout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, giving the pattern width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a transmission, sampled on the rising edge.
REQ-005 The block SHALL have port pattern, input, PAT_W bits: the word to serialize, sent MSB first.
REQ-006 The block SHALL have port reps, input, 4 bits: the number of back-to-back pattern repetitions, where 0 means 1.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of a transmission in progress.
REQ-008 The block SHALL have port serial_out, output, 1 bit: the registered serial bit stream, idle level 0.
REQ-009 The block SHALL have port busy, output, 1 bit: registered, high while the block is not accepting start.
REQ-010 The block SHALL have port done, output, 1 bit: registered, a one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, SHIFT, GAP and DONE, with IDLE as the reset state.
REQ-012 In IDLE with start=1 at an edge, the block SHALL capture pattern into a shift register, capture reps (0 becomes 1) into a repetition counter, and enter SHIFT.
REQ-013 At that same edge the block SHALL set serial_out to pattern[PAT_W-1] and set busy to 1, so the first bit is valid in the cycle after the start edge.
REQ-014 In SHIFT the block SHALL advance one bit per clock, MSB to LSB, holding each bit for exactly one cycle.
REQ-015 The block SHALL use a bit counter of width ceil(log2(PAT_W)) to track the position within a repetition, and SHALL reload the captured pattern at each repetition boundary.
REQ-016 When the last bit of a repetition is on serial_out and further repetitions remain, the next edge SHALL output the new repetition's MSB, with no idle bit between repetitions (GAP state used only per REQ-027).
REQ-017 When the last bit of the last repetition is on serial_out, the next edge SHALL enter DONE with serial_out=0, done=1 and busy=1.
REQ-018 From DONE the block SHALL return to IDLE at the next edge, with done=0 and busy=0.
REQ-019 The total transmission SHALL be reps*PAT_W bit-cycles (plus gap cycles when enabled), followed by exactly one done cycle.
REQ-020 While busy=1, start SHALL be ignored, and pattern and reps SHALL not affect the transmission in progress.
REQ-021 abort=1 in SHIFT or GAP SHALL cause a transition to IDLE at the next edge with serial_out=0, busy=0 and no done pulse.
REQ-022 abort SHALL take priority over all other transitions, and abort in IDLE or DONE SHALL have no effect.
REQ-023 If start=1 and abort=1 coincide in IDLE, start SHALL be honoured.

Reset
REQ-024 When n_rst=0, the block SHALL immediately force the state to IDLE and set serial_out=0, busy=0, done=0, and clear all counters and the shift register, regardless of the clock.
REQ-025 A reset asserted mid-transmission SHALL discard the transmission with no done pulse, and after release the block SHALL wait for a new start.

Configuration
REQ-026 The block SHALL support the preprocessor macro SEQ_TX_GAP_EN.
REQ-027 With SEQ_TX_GAP_EN defined, the block SHALL insert one GAP cycle (serial_out=0, busy=1) between consecutive repetitions, but not after the last repetition.
REQ-028 Without SEQ_TX_GAP_EN, the GAP state SHALL be unreachable and repetitions SHALL be strictly back-to-back.

Verification
REQ-029 The bench SHALL cover: PAT_W=4, pattern=1101, reps=1, start at edge 0 -> serial_out 1,1,0,1 in cycles 1-4, done=1 in cycle 5, busy=0 from cycle 6.
REQ-030 The bench SHALL cover: pattern=1101, reps=3, no gap macro -> serial_out 110111011101 in cycles 1-12, done in cycle 13.
REQ-031 The bench SHALL cover: same stimulus as REQ-030 with SEQ_TX_GAP_EN defined -> serial_out 11010110101101 in cycles 1-14, done in cycle 15.
REQ-032 The bench SHALL cover: reps=0, pattern=1010 -> exactly one repetition, 1,0,1,0, then done in cycle 5.
REQ-033 The bench SHALL cover: start pulsed again with pattern=0110 in cycle 2 of a 1101 transmission -> ignored, stream unchanged; abort in cycle 3 -> serial_out=0 and busy=0 in cycle 4, with no done.
REQ-034 The bench SHALL cover: n_rst asserted between clock edges in cycle 2 -> serial_out, busy and done go to 0 immediately, with no done pulse after release.
